// File: rtl/svi_mux_pkg.sv
// Shared types and default sizes for the svi channel selector.
package svi_mux_pkg;

   // Arbitration mode: fixed channel index or rotating fair share.
   typedef enum logic {
      MODE_STATIC = 1'b0,
      MODE_RR     = 1'b1
   } mode_e;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_N_CH  = 4;
   localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/svi_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr,
// wrapping modulo N_CH, and moves ptr past the winner when a grant is taken.
module svi_rr_arbiter
   import svi_mux_pkg::*;
#(
   parameter  int N_CH  = DEF_N_CH,
   localparam int SEL_W = $clog2(N_CH)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [N_CH-1:0]   i_req,
   input  logic              i_advance,
   input  logic              i_enable,
   output logic [N_CH-1:0]   o_grant_oh,
   output logic [SEL_W-1:0]  o_grant_idx,
   output logic              o_grant_vld
);

   logic [SEL_W-1:0] ptr_reg;
   logic [SEL_W-1:0] ptr_next;
   int               cand;
   logic [SEL_W-1:0] cand_idx;

   // Search from ptr upward with explicit wrap so non-power-of-2 counts work.
   always_comb begin
      o_grant_oh  = '0;
      o_grant_idx = '0;
      o_grant_vld = 1'b0;
      cand        = 0;
      cand_idx    = '0;
      if (i_enable) begin
         for (int i = 0; i < N_CH; i++) begin
            cand = int'(ptr_reg) + i;
            if (cand >= N_CH) begin
               cand = cand - N_CH;
            end
            cand_idx = SEL_W'(cand);
            if (!o_grant_vld && i_req[cand_idx]) begin
               o_grant_vld = 1'b1;
               o_grant_idx = cand_idx;
            end
         end
         if (o_grant_vld) begin
            o_grant_oh[o_grant_idx] = 1'b1;
         end
      end
   end

   // Next pointer is one past the winner; the top channel wraps back to zero.
   always_comb begin
      ptr_next = ptr_reg;
      if (i_enable && i_advance && o_grant_vld) begin
         ptr_next = (o_grant_idx == SEL_W'(N_CH - 1)) ? '0 : o_grant_idx + SEL_W'(1);
      end
   end

   // Pointer register; only moves on a taken round-robin grant.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         ptr_reg <= '0;
      end else begin
         ptr_reg <= ptr_next;
      end
   end

endmodule

// File: rtl/svi_mux_arb.sv
// N-channel selector with a single registered output stage, valid/ready on
// every side, static or round-robin channel choice, sticky bad-select flag
// and an output transfer counter.
module svi_mux_arb
   import svi_mux_pkg::*;
#(
   parameter  int WIDTH = DEF_WIDTH,
   parameter  int N_CH  = DEF_N_CH,
   parameter  int CNT_W = DEF_CNT_W,
   localparam int SEL_W = $clog2(N_CH)
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic [N_CH-1:0][WIDTH-1:0]  i_data,
   input  logic [N_CH-1:0]             i_valid,
   output logic [N_CH-1:0]             o_ready,
   input  mode_e                       i_mode,
   input  logic [SEL_W-1:0]            i_sel,
   output logic [WIDTH-1:0]            o_y,
   output logic [SEL_W-1:0]            o_ch,
   output logic                        o_valid,
   input  logic                        i_ready,
   output logic                        o_sel_err,
   output logic [CNT_W-1:0]            o_xfer_cnt
);

   localparam logic [SEL_W:0] N_CH_EXT = (SEL_W + 1)'(N_CH);

   logic [WIDTH-1:0] y_reg;
   logic [SEL_W-1:0] ch_reg;
   logic             valid_reg;
   logic             sel_err_reg;
   logic [CNT_W-1:0] cnt_reg;

   logic             sel_ok;
   logic [N_CH-1:0]  st_oh;
   logic [N_CH-1:0]  rr_oh;
   logic [SEL_W-1:0] rr_idx;
   logic             rr_vld;
   logic             is_rr;
   logic [N_CH-1:0]  grant_oh;
   logic [SEL_W-1:0] grant_idx;
   logic             grant_vld;
   logic             load;
   logic             take;

   assign is_rr  = (i_mode == MODE_RR);
   assign sel_ok = ({1'b0, i_sel} < N_CH_EXT);

   // Static path: a channel is granted only if the index exists and it is valid.
   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_static
         assign st_oh[gi] = sel_ok && (i_sel == SEL_W'(gi)) && i_valid[gi];
      end
   endgenerate

   svi_rr_arbiter #(.N_CH(N_CH)) u_rr (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_req       (i_valid),
      .i_advance   (take),
      .i_enable    (is_rr),
      .o_grant_oh  (rr_oh),
      .o_grant_idx (rr_idx),
      .o_grant_vld (rr_vld)
   );

   assign grant_oh  = is_rr ? rr_oh  : st_oh;
   assign grant_idx = is_rr ? rr_idx : i_sel;
   assign grant_vld = is_rr ? rr_vld : (|st_oh);

   // Single output register without a skid slot: it accepts whenever it is
   // empty or being drained this cycle, so ready depends on i_ready directly.
   assign load    = !valid_reg || i_ready;
   assign take    = load && grant_vld && !i_rst;
   assign o_ready = (load && !i_rst) ? grant_oh : '0;

   // Output stage: capture the granted channel, or empty out when nothing is granted.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         y_reg     <= '0;
         ch_reg    <= '0;
         valid_reg <= 1'b0;
      end else if (load) begin
         if (take) begin
            y_reg     <= i_data[grant_idx];
            ch_reg    <= grant_idx;
            valid_reg <= 1'b1;
         end else begin
            valid_reg <= 1'b0;
         end
      end
   end

   // Sticky flag for a static select that names a channel that does not exist.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sel_err_reg <= 1'b0;
      end else if (!is_rr && !sel_ok) begin
         sel_err_reg <= 1'b1;
      end
   end

   // Count completed output handshakes, wrapping naturally.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_reg <= '0;
      end else if (valid_reg && i_ready) begin
         cnt_reg <= cnt_reg + CNT_W'(1);
      end
   end

   assign o_y        = y_reg;
   assign o_ch       = ch_reg;
   assign o_valid    = valid_reg;
   assign o_sel_err  = sel_err_reg;
   assign o_xfer_cnt = cnt_reg;

endmodule
